// File: rtl/stream_demux_pkg.sv
// Shared types for the 1:4 stream demultiplexer.
//   N_CHAN       : number of downstream channels
//   chan_sel_t   : channel select encoding (0..3)
//   slot_state_t : per-channel holding-register state
package stream_demux_pkg;
  localparam int N_CHAN = 4;
  typedef logic [1:0] chan_sel_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel, plus its
// delivered-word counter.
//   clk, rst    : clock, synchronous active-high reset
//   load        : write load_data into the slot this cycle
//   load_data   : word to store
//   dn_ready    : downstream ready
//   dn_valid    : slot holds a word (also tells the top the slot is full)
//   dn_data     : registered slot contents
//   dn_count    : downstream transfers seen, wraps modulo 2^CNT_W
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic [W-1:0]     dn_data,
  output logic [CNT_W-1:0] dn_count
);

  slot_state_t      state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  assign drain = (state_q == SLOT_FULL) && dn_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, drain};
    // A load wins over a drain: when both happen the slot stays full with
    // the new word, giving one word per cycle through an always-ready channel.
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dn_valid = (state_q == SLOT_FULL);
  assign dn_data  = data_q;
  assign dn_count = cnt_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer with valid/ready flow control.
//   clk, rst  : clock, synchronous active-high reset
//   up_valid  : upstream word valid
//   up_ready  : word accepted this cycle (combinational from up_sel/slots/dn_ready)
//   up_data   : upstream word, W bits
//   up_sel    : destination channel
//   dn_valid  : per-channel valid, bit i = channel i
//   dn_ready  : per-channel ready
//   dn_data   : channel i at [i*W +: W]
//   dn_count  : channel i delivered count at [i*CNT_W +: CNT_W]
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [W-1:0]            up_data,
  input  logic [1:0]              up_sel,
  output logic [N_CHAN-1:0]       dn_valid,
  input  logic [N_CHAN-1:0]       dn_ready,
  output logic [N_CHAN*W-1:0]     dn_data,
  output logic [N_CHAN*CNT_W-1:0] dn_count
);

  chan_sel_t         sel;
  logic [N_CHAN-1:0] load;

  assign sel = up_sel;

  // Only the selected channel gates acceptance; a stalled slot elsewhere
  // never back-pressures words headed for other channels.
  assign up_ready = !dn_valid[sel] || dn_ready[sel];

  for (genvar i = 0; i < N_CHAN; i++) begin : g_slot
    assign load[i] = up_valid && up_ready && (sel == chan_sel_t'(i));

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (up_data),
      .dn_ready  (dn_ready[i]),
      .dn_valid  (dn_valid[i]),
      .dn_data   (dn_data[i*W +: W]),
      .dn_count  (dn_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
module tb_stream_demux_1_4;
  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [W-1:0]  up_data;
  logic [1:0]    up_sel;
  logic [3:0]    dn_valid;
  logic [3:0]    dn_ready;
  logic [4*W-1:0]     dn_data;
  logic [4*CNT_W-1:0] dn_count;

  stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .up_sel   (up_sel),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_data  (dn_data),
    .dn_count (dn_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference: each channel is a FIFO of words not yet delivered, plus a
  // delivered count kept as a plain integer reduced mod 256 at compare time.
  logic [W-1:0] mq[4][$];
  int           mcnt[4];
  logic         exp_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    exp_ready = (mq[up_sel].size() == 0) || dn_ready[up_sel];
    chk("up_ready", {31'd0, up_ready}, {31'd0, exp_ready});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid%0d", i), {31'd0, dn_valid[i]}, {31'd0, mq[i].size() > 0});
      if (mq[i].size() > 0)
        chk($sformatf("data%0d", i), {28'd0, dn_data[i*W +: W]}, {28'd0, mq[i][0]});
      chk($sformatf("cnt%0d", i), {24'd0, dn_count[i*CNT_W +: CNT_W]}, mcnt[i] % 256);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mcnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (mq[i].size() > 0 && dn_ready[i]) begin
          void'(mq[i].pop_front());
          mcnt[i]++;
        end
      if (up_valid && exp_ready) mq[up_sel].push_back(up_data);
    end
  endtask

  // One clock: drive at the negedge, check mid-low-phase, update model at posedge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] s,
                     input logic [W-1:0] d, input logic [3:0] rdy);
    rst = r; up_valid = v; up_sel = s; up_data = d; dn_ready = rdy;
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    rst = 1'b1; up_valid = 1'b0; up_sel = 2'd0; up_data = '0; dn_ready = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {28'd0, dn_valid}, 32'h0);
    chk("rst_data",  {16'd0, dn_data}, 32'h0);
    chk("rst_cnt",   dn_count, 32'h0);
    chk("rst_ready", {31'd0, up_ready}, 32'h1);
    @(negedge clk);

    // 1: one word per channel, each lands next cycle
    cyc(0, 1, 0, 4'ha, 4'hf);
    chk("t1_v0", {28'd0, dn_valid}, 32'h1);
    chk("t1_d0", {28'd0, dn_data[3:0]}, 32'ha);
    cyc(0, 1, 1, 4'hb, 4'hf);
    chk("t1_v1", {28'd0, dn_valid}, 32'h2);
    cyc(0, 1, 2, 4'hc, 4'hf);
    chk("t1_v2", {28'd0, dn_valid}, 32'h4);
    cyc(0, 1, 3, 4'hd, 4'hf);
    chk("t1_v3", {28'd0, dn_valid}, 32'h8);
    chk("t1_d3", {28'd0, dn_data[15:12]}, 32'hd);
    cyc(0, 0, 0, 4'h0, 4'hf);
    chk("t1_cnt", dn_count, 32'h01010101);

    // 2: stall channel 2
    cyc(0, 1, 2, 4'h5, 4'b1011);
    chk("t2_d2", {28'd0, dn_data[11:8]}, 32'h5);
    up_valid = 1'b1; up_sel = 2'd2; up_data = 4'h6; dn_ready = 4'b1011;
    #1;
    chk("t2_stall", {31'd0, up_ready}, 32'h0);
    @(negedge clk);
    // 3: other channels still flow past the stalled one
    cyc(0, 1, 0, 4'h7, 4'b1011);
    chk("t3_d0", {28'd0, dn_data[3:0]}, 32'h7);
    cyc(0, 1, 3, 4'h8, 4'b1011);
    chk("t3_d3", {28'd0, dn_data[15:12]}, 32'h8);
    cyc(0, 0, 0, 4'h0, 4'b1011);
    chk("t3_hold", {28'd0, dn_data[11:8]}, 32'h5);
    chk("t3_v2", {31'd0, dn_valid[2]}, 32'h1);
    // 2 cont: release: 5 drains and 6 loads in the same cycle
    cyc(0, 1, 2, 4'h6, 4'hf);
    chk("t2_d2b", {28'd0, dn_data[11:8]}, 32'h6);
    chk("t2_cnt2", {24'd0, dn_count[23:16]}, 32'h2);
    cyc(0, 0, 0, 4'h0, 4'hf);

    // 4: 300 back-to-back words to channel 1, from a clean count
    cyc(1, 0, 0, 4'h0, 4'hf);
    for (int k = 0; k < 300; k++) cyc(0, 1, 1, 4'(k), 4'hf);
    cyc(0, 0, 0, 4'h0, 4'hf);
    chk("t4_cnt1", {24'd0, dn_count[15:8]}, 32'd44);

    // 5: reset with all slots full and stalled
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'(k), 4'(k + 1), 4'h0);
    chk("t5_full", {28'd0, dn_valid}, 32'hf);
    cyc(1, 0, 0, 4'h0, 4'h0);
    chk("t5_valid", {28'd0, dn_valid}, 32'h0);
    chk("t5_cnt", dn_count, 32'h0);
    up_sel = 2'd1; #1;
    chk("t5_ready", {31'd0, up_ready}, 32'h1);
    @(negedge clk);
    cyc(0, 0, 0, 4'h0, 4'hf);
    chk("t5_nostale", {28'd0, dn_valid}, 32'h0);

    // 6: random stress
    for (int k = 0; k < 10000; k++)
      cyc(0, 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 4'h0, 4'hf);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drained%0d", i), {31'd0, dn_valid[i]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Registered 1-to-4 stream demultiplexer; the counterpart to the 4:1 mux path, which merges four sources into one.
- Steers each accepted upstream word to one of four downstream channels, selected by up_sel.
- Uses valid/ready flow control with a one-entry holding register per channel, so a stalled channel does not block words destined for other channels.
- Keeps a per-channel delivered-word counter for debug and verification.

Parameters:
- W, 4, data width in bits.
- CNT_W, 8, width of each per-channel delivered counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  block accepts the word this cycle.
- up_data  input  W  upstream data.
- up_sel  input  2  destination channel (0..3); sampled together with up_data.
- dn_valid  output  4  per-channel valid; bit i belongs to channel i.
- dn_ready  input  4  per-channel ready.
- dn_data  output  4*W  channel i occupies bits [i*W +: W].
- dn_count  output  4*CNT_W  channel i delivered-word count at [i*CNT_W +: CNT_W].

Behaviour:
- Reset: all dn_valid = 0, all dn_data = 0, all dn_count = 0. up_ready is combinational and therefore reads 1 immediately after reset.
- Slot state: each channel has a 2-state slot, EMPTY or FULL. dn_valid[i] = (slot i == FULL). dn_data slice i is the registered slot contents.
- Upstream transfer: occurs when up_valid && up_ready.
- up_ready = !full[up_sel] || dn_ready[up_sel]. up_ready is combinational from up_sel, slot state and dn_ready. It does not depend on up_valid.
- Slot i transitions:
  - EMPTY, with an accepted word targeted at i -> FULL; data is loaded.
  - FULL, dn_ready[i], no new load -> EMPTY.
  - FULL, dn_ready[i], with a load targeted at i -> stays FULL; new data replaces the old in the same cycle (pass-through at full throughput).
  - FULL, !dn_ready[i] -> holds; dn_data is stable.
- Latency: a word accepted in cycle N appears on dn_valid/dn_data in cycle N+1. A channel whose receiver is always ready sustains one word per cycle.
- Independence: a stalled channel blocks only upstream words targeted at it (up_ready = 0 while up_sel points at it). Data in other slots keeps draining.
- Counter: dn_count[i] increments on each downstream transfer (dn_valid[i] && dn_ready[i]). It wraps modulo 2^CNT_W with no saturation. Several channels can increment in the same cycle.
- Simultaneous events: a drain on channel j and a load on channel k (j != k) in one cycle are both honoured.
- Upstream protocol: up_sel and up_data need not be stable while up_valid is held. The block samples them only on the transfer cycle.
- Reset mid-operation: any FULL slot is discarded; no word is emitted after reset. Counters clear.
- Unknown up_sel (X) with up_valid = 1 is illegal upstream. No X tolerance is required.

Decomposition:
- Package stream_demux_pkg holds:
  - localparam N_CHAN = 4;
  - typedef logic [1:0] chan_sel_t;
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
- Sub-module demux_slot: one-entry holding register with load/valid/ready, parameterised by W, plus its counter (CNT_W). It is instantiated four times via generate.
- The top level holds only the up_sel decode, the load enables, and the up_ready mux.

Test Plan:
1. After reset with dn_ready = 4'hF, send 'ha/sel 0, 'hb/sel 1, 'hc/sel 2, 'hd/sel 3 on consecutive cycles -> each dn_data[i] carries its value one cycle later, exactly one dn_valid bit high per cycle, and dn_count = {1,1,1,1}.
2. Hold dn_ready[2] = 0, send 'h5/sel 2 then 'h6/sel 2 -> the first word is accepted, up_ready = 0 for the second, and dn_data[2] holds 'h5. Raise dn_ready[2] -> 'h5 is delivered and 'h6 is accepted in the same cycle, then appears next cycle.
3. Channel 2 stalled and full; send 'h7/sel 0 and 'h8/sel 3 -> both are accepted and delivered while channel 2 stays at 'h5.
4. Stream 300 words to sel 1 with dn_ready = 1 -> one word per cycle, data order preserved, and dn_count[1] = 300 mod 256 = 44.
5. Fill all four slots with dn_ready = 0, then assert rst for one cycle -> dn_valid = 0, dn_count = 0 and up_ready = 1 the cycle after, with no stale word emitted.
6. Random stress: random up_valid, up_sel and dn_ready over 10k cycles, checked against a per-channel queue model -> no loss, no duplication, per-channel order kept, and counters match the model.
